// File: rtl/feature_transfer_pkg.sv
// Shared definitions for the SPI feature-stream receiver: FSM encoding,
// default inactivity timeout and frame-length limit.
package feature_transfer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GET_LENGTH,
        GET_FEATURE,
        DONE,
        ERROR
    } rxState_t;

    localparam int DEFAULT_IDLE_TIMEOUT = 64;
    localparam int MAX_FEATURES         = 126;

    function automatic int bytesFor(input int bits);
        return (bits + 7) / 8;
    endfunction

endpackage

// File: rtl/spi_byte_receiver.sv
// SPI mode-3 byte deserializer: synchronizes SCK/MOSI, shifts MSB first on SCK
// rising edges, and aborts partial bytes/frames after a period of SCK inactivity.
module spi_byte_receiver
    import feature_transfer_pkg::*;
#(
    parameter int IDLE_TIMEOUT = DEFAULT_IDLE_TIMEOUT
) (
    input  logic       systemClock,
    input  logic       reset,
    input  logic       spiSck,
    input  logic       spiMosi,
    input  logic       frameActive,
    output logic       byteValid,
    output logic [7:0] byteData,
    output logic       abort
);
    localparam int CW = $clog2(IDLE_TIMEOUT + 1);

    logic [1:0]    sckSync;
    logic [1:0]    mosiSync;
    logic          sckPrev;
    logic [2:0]    bitCnt;
    logic [CW-1:0] idleCnt;
    logic          sckEdge;
    logic          sckRise;
    logic          timeoutHit;

    assign sckEdge    = sckSync[1] ^ sckPrev;
    assign sckRise    = sckSync[1] & ~sckPrev;
    // Fires on the cycle the counter steps onto IDLE_TIMEOUT; saturation keeps it one-shot.
    assign timeoutHit = !sckEdge && (idleCnt == CW'(IDLE_TIMEOUT - 1));

    always_ff @(posedge systemClock or posedge reset) begin
        if (reset) begin
            sckSync   <= 2'b11;
            mosiSync  <= 2'b11;
            sckPrev   <= 1'b1;
            bitCnt    <= '0;
            idleCnt   <= '0;
            byteData  <= '0;
            byteValid <= 1'b0;
            abort     <= 1'b0;
        end else begin
            sckSync   <= {sckSync[0], spiSck};
            mosiSync  <= {mosiSync[0], spiMosi};
            sckPrev   <= sckSync[1];
            byteValid <= 1'b0;
            abort     <= 1'b0;

            if (sckEdge)
                idleCnt <= '0;
            else if (idleCnt != CW'(IDLE_TIMEOUT))
                idleCnt <= idleCnt + 1'b1;

            if (timeoutHit) begin
                bitCnt <= '0;
                abort  <= frameActive || (bitCnt != 3'd0);
            end else if (sckRise) begin
                byteData  <= {byteData[6:0], mosiSync[1]};
                bitCnt    <= bitCnt + 3'd1;
                byteValid <= (bitCnt == 3'd7);
            end
        end
    end

endmodule

// File: rtl/feature_spi_receiver.sv
// Decodes a framed SPI stream (frameCount, length, then length features sent
// LSB byte first) into feature pulses plus frame status pulses.
module feature_spi_receiver
    import feature_transfer_pkg::*;
#(
    parameter int NUM_BITS_X   = 10,
    parameter int NUM_BITS_Y   = 9,
    parameter int IDLE_TIMEOUT = DEFAULT_IDLE_TIMEOUT
) (
    input  logic                                   systemClock,
    input  logic                                   reset,
    input  logic                                   spiSck,
    input  logic                                   spiMosi,
    output logic                                   featureValid,
    output logic [(NUM_BITS_X+NUM_BITS_Y)*2-1:0]   featureVector,
    output logic [6:0]                             featureIndex,
    output logic [7:0]                             frameCount,
    output logic [7:0]                             featureCount,
    output logic                                   frameDone,
    output logic                                   frameError,
    output logic                                   frameSkip
);
    localparam int FW = (NUM_BITS_X + NUM_BITS_Y) * 2;
    localparam int NB = bytesFor(FW);
    localparam int LW = (NB > 1) ? (NB - 1) * 8 : 8;

    rxState_t      state;
    logic [LW-1:0] lowBytes;
    logic [2:0]    byteIdx;
    logic          historyValid;
    logic          byteValid;
    logic [7:0]    byteData;
    logic          abort;

    spi_byte_receiver #(.IDLE_TIMEOUT(IDLE_TIMEOUT)) byteRx (
        .systemClock (systemClock),
        .reset       (reset),
        .spiSck      (spiSck),
        .spiMosi     (spiMosi),
        .frameActive (state != IDLE),
        .byteValid   (byteValid),
        .byteData    (byteData),
        .abort       (abort)
    );

    always_ff @(posedge systemClock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            lowBytes      <= '0;
            byteIdx       <= '0;
            historyValid  <= 1'b0;
            featureValid  <= 1'b0;
            featureVector <= '0;
            featureIndex  <= '0;
            frameCount    <= '0;
            featureCount  <= '0;
            frameDone     <= 1'b0;
            frameError    <= 1'b0;
            frameSkip     <= 1'b0;
        end else begin
            featureValid <= 1'b0;
            frameDone    <= 1'b0;
            frameError   <= 1'b0;
            frameSkip    <= 1'b0;
            if (featureValid)
                featureIndex <= featureIndex + 7'd1;

            if (abort) begin
                state <= ERROR;
            end else begin
                case (state)
                    IDLE: if (byteValid) begin
                        frameSkip    <= historyValid && (byteData != frameCount + 8'd1);
                        frameCount   <= byteData;
                        historyValid <= 1'b1;
                        state        <= GET_LENGTH;
                    end
                    GET_LENGTH: if (byteValid) begin
                        featureCount <= byteData;
                        if (byteData > 8'(MAX_FEATURES)) begin
                            state <= ERROR;
                        end else if (byteData == 8'd0) begin
                            state <= DONE;
                        end else begin
                            featureIndex <= '0;
                            byteIdx      <= '0;
                            state        <= GET_FEATURE;
                        end
                    end
                    GET_FEATURE: if (byteValid) begin
                        if (byteIdx == 3'(NB - 1)) begin
                            // Final byte completes the word; padding above FW-1 falls off here.
                            featureVector <= (NB > 1) ? FW'({byteData, lowBytes}) : FW'(byteData);
                            featureValid  <= 1'b1;
                            byteIdx       <= '0;
                            if ({1'b0, featureIndex} == featureCount - 8'd1)
                                state <= DONE;
                        end else begin
                            lowBytes[int'(byteIdx)*8 +: 8] <= byteData;
                            byteIdx <= byteIdx + 3'd1;
                        end
                    end
                    DONE: begin
                        frameDone <= 1'b1;
                        state     <= IDLE;
                    end
                    ERROR: begin
                        frameError <= 1'b1;
                        state      <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_feature_spi_receiver.sv
// Directed + randomized bench for feature_spi_receiver against a frame-level model.
module tb_feature_spi_receiver;
    localparam int FW = 38;
    localparam int NB = 5;

    logic          systemClock = 1'b0;
    logic          reset = 1'b1;
    logic          spiSck = 1'b1;
    logic          spiMosi = 1'b1;
    logic          featureValid;
    logic [FW-1:0] featureVector;
    logic [6:0]    featureIndex;
    logic [7:0]    frameCount;
    logic [7:0]    featureCount;
    logic          frameDone;
    logic          frameError;
    logic          frameSkip;

    always #5 systemClock = ~systemClock;

    feature_spi_receiver dut (
        .systemClock   (systemClock),
        .reset         (reset),
        .spiSck        (spiSck),
        .spiMosi       (spiMosi),
        .featureValid  (featureValid),
        .featureVector (featureVector),
        .featureIndex  (featureIndex),
        .frameCount    (frameCount),
        .featureCount  (featureCount),
        .frameDone     (frameDone),
        .frameError    (frameError),
        .frameSkip     (frameSkip)
    );

    // Observed pulses, sampled away from the active edge.
    logic [FW-1:0] gotVec[$];
    int            gotIdx[$];
    int            doneCnt = 0;
    int            errCnt = 0;
    int            skipCnt = 0;

    always @(negedge systemClock) begin
        if (featureValid) begin
            gotVec.push_back(featureVector);
            gotIdx.push_back(int'(featureIndex));
        end
        if (frameDone)  doneCnt++;
        if (frameError) errCnt++;
        if (frameSkip)  skipCnt++;
    end

    // Frame-level reference model state.
    logic [FW-1:0] expVec[$];
    int            expIdx[$];
    logic [FW-1:0] pending[$];
    int            expDone, expErr, expSkip;
    int            baseVec, baseDone, baseErr, baseSkip;
    bit            prevValid = 1'b0;
    logic [7:0]    prevFc = '0;
    logic [7:0]    lastFc = '0;
    logic [7:0]    lastLen = '0;
    logic [FW-1:0] holdVec = '0;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge systemClock);
    endtask

    task automatic sendBits(input logic [7:0] b, input int nbits, input int half);
        for (int i = 7; i > 7 - nbits; i--) begin
            spiSck  = 1'b0;
            spiMosi = b[i];
            tick(half);
            spiSck  = 1'b1;
            tick(half);
        end
    endtask

    task automatic sendByte(input logic [7:0] b, input int half);
        sendBits(b, 8, half);
    endtask

    task automatic startCapture;
        baseVec  = gotVec.size();
        baseDone = doneCnt;
        baseErr  = errCnt;
        baseSkip = skipCnt;
        expVec.delete();
        expIdx.delete();
        expDone = 0;
        expErr  = 0;
        expSkip = 0;
    endtask

    task automatic sendFrame(input logic [7:0] fc, input int len, input int half);
        logic [63:0] r;
        logic [39:0] w;
        if (prevValid && fc != 8'(prevFc + 8'd1)) expSkip++;
        prevFc    = fc;
        prevValid = 1'b1;
        lastFc    = fc;
        lastLen   = len[7:0];
        sendByte(fc, half);
        sendByte(len[7:0], half);
        if (len > 126) begin
            expErr++;
        end else begin
            for (int i = 0; i < len; i++) begin
                r = {$urandom(), $urandom()};
                w = r[39:0];
                if (i < pending.size()) w[FW-1:0] = pending[i];
                expVec.push_back(w[FW-1:0]);
                expIdx.push_back(i);
                holdVec = w[FW-1:0];
                for (int k = 0; k < NB; k++) sendByte(w[8*k +: 8], half);
            end
            expDone++;
        end
        pending.delete();
    endtask

    task automatic endCapture(input string tag);
        int n;
        n = gotVec.size() - baseVec;
        check({tag, " featureCnt"}, 64'(n), 64'(expVec.size()));
        for (int i = 0; i < expVec.size() && i < n; i++) begin
            check($sformatf("%s vec%0d", tag, i), 64'(gotVec[baseVec + i]), 64'(expVec[i]));
            check($sformatf("%s idx%0d", tag, i), 64'(gotIdx[baseVec + i]), 64'(expIdx[i]));
        end
        check({tag, " done"},  64'(doneCnt - baseDone), 64'(expDone));
        check({tag, " error"}, 64'(errCnt - baseErr),   64'(expErr));
        check({tag, " skip"},  64'(skipCnt - baseSkip), 64'(expSkip));
        check({tag, " frameCount"},   64'(frameCount),    64'(lastFc));
        check({tag, " featureCount"}, 64'(featureCount),  64'(lastLen));
        check({tag, " holdVector"},   64'(featureVector), 64'(holdVec));
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, " featureValid"},  64'(featureValid),  64'd0);
        check({tag, " featureVector"}, 64'(featureVector), 64'd0);
        check({tag, " featureIndex"},  64'(featureIndex),  64'd0);
        check({tag, " frameCount"},    64'(frameCount),    64'd0);
        check({tag, " featureCount"},  64'(featureCount),  64'd0);
        check({tag, " frameDone"},     64'(frameDone),     64'd0);
        check({tag, " frameError"},    64'(frameError),    64'd0);
        check({tag, " frameSkip"},     64'(frameSkip),     64'd0);
    endtask

    initial begin
        logic [7:0] fc;
        reset = 1'b1;
        tick(3);
        checkResetOutputs("reset");
        reset = 1'b0;
        tick(5);

        // Two known features, first frame after reset.
        startCapture();
        pending.push_back(38'h3F_1234_5678);
        pending.push_back(38'h00_0000_0001);
        sendFrame(8'h05, 2, 3);
        tick(12);
        endCapture("frame5");

        // Empty frame with a skipped frame number.
        startCapture();
        sendFrame(8'h07, 0, 3);
        tick(12);
        endCapture("frame7");

        // SCK stops after three bytes of a one-feature frame.
        startCapture();
        prevFc = 8'h08; lastFc = 8'h08; lastLen = 8'h01;
        sendByte(8'h08, 3);
        sendByte(8'h01, 3);
        sendByte(8'h55, 3);
        expErr = 1;
        tick(90);
        endCapture("timeout");
        startCapture();
        sendFrame(8'h09, 3, 3);
        tick(12);
        endCapture("frame9");

        // Over-long length byte.
        startCapture();
        sendFrame(8'h0A, 127, 3);
        tick(90);
        endCapture("len127");

        // Reset after 12 bits of a new frame.
        startCapture();
        sendByte(8'h0B, 3);
        sendBits(8'h80, 4, 3);
        reset = 1'b1;
        tick(3);
        checkResetOutputs("midReset");
        reset = 1'b0;
        prevValid = 1'b0; lastFc = '0; lastLen = '0; holdVec = '0;
        tick(80);
        endCapture("afterReset");
        startCapture();
        sendFrame(8'h20, 2, 3);
        tick(12);
        endCapture("frame20");

        // Back-to-back frames at the minimum half-period, maximum length first.
        startCapture();
        sendFrame(8'h21, 126, 2);
        sendFrame(8'h22, 4, 2);
        tick(12);
        endCapture("backToBack");

        // Randomized frames, mostly sequential numbering.
        for (int f = 0; f < 6; f++) begin
            fc = ($urandom_range(0, 3) == 0) ? 8'($urandom()) : 8'(prevFc + 8'd1);
            startCapture();
            sendFrame(fc, int'($urandom_range(0, 6)), int'($urandom_range(2, 4)));
            tick(12);
            endCapture($sformatf("rand%0d", f));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/feature_spi_receiver.md
FEATURE_SPI_RECEIVER -- requirements
Module: feature_spi_receiver

Interface
REQ-001 Parameter NUM_BITS_X, default 10, x-coordinate width (≤16).
REQ-002 Parameter NUM_BITS_Y, default 9, y-coordinate width (≤16).
REQ-003 Parameter IDLE_TIMEOUT, default 64, systemClock cycles of SCK inactivity that abort a partial frame.
REQ-004 systemClock  input  1  receive clock; all logic on its rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 spiSck  input  1  SPI clock, mode 3 (idles high, data sampled on rising edge).
REQ-007 spiMosi  input  1  SPI data, MSB first.
REQ-008 featureValid  output  1  one-cycle pulse; featureVector/featureIndex valid.
REQ-009 featureVector  output  FW=(NUM_BITS_X+NUM_BITS_Y)*2  reassembled feature, padding dropped.
REQ-010 featureIndex  output  7  0-based position of the feature in the current frame.
REQ-011 frameCount  output  8  frame-count byte of the current frame, held until the next header.
REQ-012 featureCount  output  8  length byte of the current frame, held.
REQ-013 frameDone  output  1  one-cycle pulse after the last feature, or after the length byte when length=0.
REQ-014 frameError  output  1  one-cycle pulse on timeout mid-frame or length>126.
REQ-015 frameSkip  output  1  one-cycle pulse when the received frameCount ≠ previous+1 (mod 256); suppressed for the first frame after reset.

Function
REQ-016 spiSck and spiMosi SHALL each pass through a 2-flop synchronizer; a rising edge of synchronized SCK SHALL shift synchronized MOSI into an 8-bit register at bit 0 (MSB first).
REQ-017 The SCK half-period SHALL be ≥2 systemClock cycles; no loss at half-period = 2.
REQ-018 After the 8th bit, a byteValid pulse SHALL assert on the next cycle and the bit counter SHALL wrap to 0.
REQ-019 Stream format: frameCount byte, length byte L, then L features of NB=ceil(FW/8) bytes each, least-significant byte first.
REQ-020 FSM states: IDLE, GET_LENGTH, GET_FEATURE, DONE, ERROR.
REQ-021 IDLE: on byteValid, latch frameCount, evaluate frameSkip, go to GET_LENGTH.
REQ-022 GET_LENGTH: on byteValid, latch featureCount; L>126 -> ERROR; L=0 -> DONE; else clear featureIndex and byte index, go to GET_FEATURE.
REQ-023 GET_FEATURE: byte k of the feature SHALL be written to bits [8k+7:8k] of the assembly register; bits above FW-1 are discarded.
REQ-024 GET_FEATURE: on byte NB-1, assert featureValid the next cycle, then increment featureIndex; after feature L-1 go to DONE.
REQ-025 DONE SHALL pulse frameDone for one cycle and then return to IDLE.
REQ-026 ERROR SHALL pulse frameError for one cycle and then return to IDLE.
REQ-027 The inactivity counter SHALL clear on every synchronized SCK edge.
REQ-028 When the inactivity counter reaches IDLE_TIMEOUT, the bit counter SHALL clear. If the FSM is not in IDLE or the bit counter is nonzero, the FSM SHALL go to ERROR; otherwise no pulse.
REQ-029 A byteValid in the same cycle as a timeout SHALL be discarded; the timeout wins.
REQ-030 featureVector SHALL hold its value between pulses.

Reset
REQ-031 On reset, all outputs SHALL be 0, the FSM SHALL be IDLE, all counters and shift registers SHALL be 0, synchronizer flops SHALL be 1 (SCK idle level), and the frameSkip history SHALL be invalidated.
REQ-032 Reset mid-frame SHALL discard partial data with no frameDone or frameError pulse; reception restarts from the next byte boundary once SCK has been idle for IDLE_TIMEOUT.

Structure
REQ-033 The FSM state encoding, IDLE_TIMEOUT default and max length 126 SHALL be defined in the shared package feature_transfer_pkg.
REQ-034 The synchronizer, edge detect, shift register and timeout logic SHALL form the sub-module spi_byte_receiver, outputs byteValid/byteData/abort.

Verification
REQ-035 Stream 0x05, 0x02, feature A 0x3F_1234_5678, feature B 0x00_0000_0001 -> two featureValid pulses (index 0, 1) with those vectors, frameCount=5, featureCount=2, one frameDone.
REQ-036 Stream 0x07, 0x00 -> frameDone 1 cycle after the length byte; no featureValid; frameSkip asserted if the previous frame was 5.
REQ-037 Stream 0x08, 0x01, then SCK stopped after 3 bytes for 64 cycles -> frameError; next full frame decodes correctly.
REQ-038 Length byte 0x7F -> frameError; no featureValid.
REQ-039 reset asserted after 12 bits, released, SCK idle ≥64 cycles, then a full frame -> outputs 0 during reset; correct decode afterwards.
REQ-040 Back-to-back frames at half-period = 2 -> all 126 features received in order with no error.
